// File: rtl/fix_session_scheduler.sv
// FIX session message scheduler: arbitrates Logon/Logout/SequenceRequest/Heartbeat,
// sequences the message builder handshake and tracks session state and MsgSeqNum.
module fix_session_scheduler #(
  parameter int SEQMEM_DEPTH = 10,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    logon_req_i,
  input  logic                    logout_req_i,
  input  logic                    seqreq_req_i,
  input  logic                    tick_i,
  input  logic [7:0]              heartBeatInt_i,
  input  logic                    msg_done_i,
  output logic                    create_message_o,
  output logic [2:0]              message_type_o,
  output logic [SEQMEM_DEPTH-1:0] msgSeqNum_o,
  output logic                    logon_ack_o,
  output logic                    logout_ack_o,
  output logic                    seqreq_ack_o,
  output logic                    session_active_o,
  output logic                    busy_o,
  output logic                    timeout_o,
  output logic [1:0]              dbg_state_o
);

  // Requests are level-held by the requester until the matching ack pulse;
  // the scheduler only samples them in IDLE, so a request dropped in the ack
  // cycle is never granted twice.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [2:0] MT_NONE   = 3'b000;
  localparam logic [2:0] MT_LOGON  = 3'b001;
  localparam logic [2:0] MT_LOGOUT = 3'b010;
  localparam logic [2:0] MT_HB     = 3'b011;
  localparam logic [2:0] MT_SEQREQ = 3'b100;

  localparam int TW = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [SEQMEM_DEPTH-1:0] SEQ_ONE = SEQMEM_DEPTH'(1);
  localparam logic [SEQMEM_DEPTH-1:0] SEQ_MAX = '1;

  state_t                  state_q, state_d;
  logic [2:0]              type_q, type_d;
  logic [SEQMEM_DEPTH-1:0] seq_q, seq_d, seq_inc;
  logic                    active_q, active_d;
  logic                    ack_logon_q, ack_logon_d;
  logic                    ack_logout_q, ack_logout_d;
  logic                    ack_seqreq_q, ack_seqreq_d;
  logic                    timeout_q, timeout_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic [7:0]              hb_cnt_q, hb_cnt_d;
  logic                    hb_pend_q, hb_pend_d;
  logic [8:0]              hb_sum;
  logic [2:0]              sel_type;
  logic                    grant;

  always_comb begin
    sel_type = MT_NONE;
    if (logout_req_i && active_q)       sel_type = MT_LOGOUT;
    else if (logon_req_i && !active_q)  sel_type = MT_LOGON;
    else if (seqreq_req_i && active_q)  sel_type = MT_SEQREQ;
    else if (hb_pend_q && active_q)     sel_type = MT_HB;
  end

  // Sequence number never returns to 0 on wrap.
  assign seq_inc = (seq_q == SEQ_MAX) ? SEQ_ONE : seq_q + SEQ_ONE;

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    seq_d        = seq_q;
    active_d     = active_q;
    ack_logon_d  = 1'b0;
    ack_logout_d = 1'b0;
    ack_seqreq_d = 1'b0;
    timeout_d    = 1'b0;
    to_cnt_d     = to_cnt_q;
    grant        = 1'b0;
    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        type_d   = MT_NONE;
        if (sel_type != MT_NONE) begin
          state_d = S_ISSUE;
          type_d  = sel_type;
          grant   = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d  = S_WAIT_DONE;
        to_cnt_d = '0;
      end
      S_WAIT_DONE: begin
        if (msg_done_i) begin
          state_d = S_IDLE;
          type_d  = MT_NONE;
          seq_d   = seq_inc;
          case (type_q)
            MT_LOGON: begin
              ack_logon_d = 1'b1;
              active_d    = 1'b1;
            end
            MT_LOGOUT: begin
              ack_logout_d = 1'b1;
              active_d     = 1'b0;
              seq_d        = SEQ_ONE;
            end
            MT_SEQREQ: ack_seqreq_d = 1'b1;
            default: ;
          endcase
        end else if (to_cnt_q == TO_LAST) begin
          // Abandoned message: no ack, sequence and session untouched.
          state_d   = S_IDLE;
          type_d    = MT_NONE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        type_d  = MT_NONE;
      end
    endcase
  end

  // Heartbeat interval tracking; a completed message restarts the interval.
  always_comb begin
    hb_cnt_d  = hb_cnt_q;
    hb_pend_d = hb_pend_q;
    hb_sum    = {1'b0, hb_cnt_q} + 9'd1;
    if (!active_q) begin
      hb_cnt_d  = 8'd0;
      hb_pend_d = 1'b0;
    end else begin
      if (grant) hb_pend_d = 1'b0;
      if (msg_done_i) begin
        hb_cnt_d = 8'd0;
      end else if (tick_i && (heartBeatInt_i != 8'd0)) begin
        if (hb_sum >= {1'b0, heartBeatInt_i}) begin
          hb_pend_d = 1'b1;
          hb_cnt_d  = 8'd0;
        end else begin
          hb_cnt_d = hb_sum[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      type_q       <= MT_NONE;
      seq_q        <= SEQ_ONE;
      active_q     <= 1'b0;
      ack_logon_q  <= 1'b0;
      ack_logout_q <= 1'b0;
      ack_seqreq_q <= 1'b0;
      timeout_q    <= 1'b0;
      to_cnt_q     <= '0;
      hb_cnt_q     <= 8'd0;
      hb_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      seq_q        <= seq_d;
      active_q     <= active_d;
      ack_logon_q  <= ack_logon_d;
      ack_logout_q <= ack_logout_d;
      ack_seqreq_q <= ack_seqreq_d;
      timeout_q    <= timeout_d;
      to_cnt_q     <= to_cnt_d;
      hb_cnt_q     <= hb_cnt_d;
      hb_pend_q    <= hb_pend_d;
    end
  end

  assign create_message_o = (state_q == S_ISSUE);
  assign message_type_o   = type_q;
  assign msgSeqNum_o      = seq_q;
  assign logon_ack_o      = ack_logon_q;
  assign logout_ack_o     = ack_logout_q;
  assign seqreq_ack_o     = ack_seqreq_q;
  assign session_active_o = active_q;
  assign busy_o           = (state_q != S_IDLE);
  assign timeout_o        = timeout_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fix_session_scheduler.sv
// Directed bench for fix_session_scheduler: expected message types queued at request
// time and checked when create_message_o fires; session/sequence tracked by a small model.
module tb_fix_session_scheduler;

  logic       clk;
  logic       rst;
  logic       logon_req_i, logout_req_i, seqreq_req_i, tick_i, msg_done_i;
  logic [7:0] heartBeatInt_i;
  logic       create_message_o;
  logic [2:0] message_type_o;
  logic [1:0] msgSeqNum_o;
  logic       logon_ack_o, logout_ack_o, seqreq_ack_o;
  logic       session_active_o, busy_o, timeout_o;
  logic [1:0] dbg_state_o;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  logic [1:0] exp_seq;
  logic       exp_active;

  fix_session_scheduler #(.SEQMEM_DEPTH(2), .DONE_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .logon_req_i      (logon_req_i),
    .logout_req_i     (logout_req_i),
    .seqreq_req_i     (seqreq_req_i),
    .tick_i           (tick_i),
    .heartBeatInt_i   (heartBeatInt_i),
    .msg_done_i       (msg_done_i),
    .create_message_o (create_message_o),
    .message_type_o   (message_type_o),
    .msgSeqNum_o      (msgSeqNum_o),
    .logon_ack_o      (logon_ack_o),
    .logout_ack_o     (logout_ack_o),
    .seqreq_ack_o     (seqreq_ack_o),
    .session_active_o (session_active_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] next_seq(input logic [1:0] s);
    return (s == 2'd3) ? 2'd1 : s + 2'd1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_create"}, create_message_o, 0);
    check({tag, "_type"}, message_type_o, 0);
    check({tag, "_seq"}, msgSeqNum_o, 1);
    check({tag, "_acks"}, {logon_ack_o, logout_ack_o, seqreq_ack_o}, 0);
    check({tag, "_active"}, session_active_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  // Scoreboard pop: wait a bounded number of cycles for create, then compare.
  task automatic wait_create(input int maxc);
    logic [2:0] e;
    int n = 0;
    while (!create_message_o && n < maxc) begin
      step();
      n++;
    end
    check("create_seen", create_message_o, 1);
    check("exp_q_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("msg_type", message_type_o, e);
    end
    check("seq_at_issue", msgSeqNum_o, exp_seq);
    check("busy_at_issue", busy_o, 1);
  endtask

  // Finish the granted message: done raised after gap WAIT_DONE steps.
  task automatic complete(input int gap, input logic [2:0] t, input logic tk);
    for (int i = 0; i < gap; i++) begin
      step();
      check("type_stable", message_type_o, t);
    end
    msg_done_i = 1'b1;
    tick_i     = tk;
    step();
    msg_done_i = 1'b0;
    tick_i     = 1'b0;
    check("logon_ack", logon_ack_o, (t == 3'b001));
    check("logout_ack", logout_ack_o, (t == 3'b010));
    check("seqreq_ack", seqreq_ack_o, (t == 3'b100));
    if (t == 3'b001) exp_active = 1'b1;
    if (t == 3'b010) begin
      exp_active = 1'b0;
      exp_seq    = 2'd1;
    end else begin
      exp_seq = next_seq(exp_seq);
    end
    check("seq_after_done", msgSeqNum_o, exp_seq);
    check("active_after_done", session_active_o, exp_active);
    check("busy_after_done", busy_o, 0);
    check("type_idle", message_type_o, 0);
    case (t)
      3'b001:  logon_req_i  = 1'b0;
      3'b010:  logout_req_i = 1'b0;
      3'b100:  seqreq_req_i = 1'b0;
      default: ;
    endcase
    step();
    check("acks_one_cycle", {logon_ack_o, logout_ack_o, seqreq_ack_o}, 0);
  endtask

  task automatic pulse_tick();
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    logon_req_i = 0; logout_req_i = 0; seqreq_req_i = 0;
    tick_i = 0; msg_done_i = 0; heartBeatInt_i = 8'd0;
    exp_seq = 2'd1;
    exp_active = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");

    // Stray done right after reset release yields nothing.
    rst = 1'b0;
    msg_done_i = 1'b1;
    step();
    msg_done_i = 1'b0;
    check("post_reset_done_acks", {logon_ack_o, logout_ack_o, seqreq_ack_o}, 0);
    check("post_reset_done_seq", msgSeqNum_o, 1);

    // Logout/seqreq while inactive are ineligible.
    logout_req_i = 1'b1;
    seqreq_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("inactive_ignore_busy", busy_o, 0);
    end
    logout_req_i = 1'b0;
    seqreq_req_i = 1'b0;
    step();

    // Logon: create next cycle, done in 4th WAIT_DONE cycle beats the timeout.
    exp_q.push_back(3'b001);
    logon_req_i = 1'b1;
    step();
    wait_create(0);
    complete(4, 3'b001, 1'b0);

    // Two sequence requests; second wraps 3 -> 1.
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(3'b100);
      seqreq_req_i = 1'b1;
      step();
      wait_create(1);
      complete(2, 3'b100, 1'b0);
    end

    // Heartbeat after three ticks.
    heartBeatInt_i = 8'd3;
    for (int k = 0; k < 2; k++) begin
      pulse_tick();
      step();
      check("hb_not_yet", busy_o, 0);
    end
    exp_q.push_back(3'b011);
    pulse_tick();
    wait_create(1);
    complete(1, 3'b011, 1'b0);

    // Suppression: seqreq completes with a coincident tick after two ticks.
    pulse_tick();
    pulse_tick();
    exp_q.push_back(3'b100);
    seqreq_req_i = 1'b1;
    step();
    wait_create(1);
    complete(2, 3'b100, 1'b1);
    for (int k = 0; k < 2; k++) begin
      pulse_tick();
      step();
      step();
      check("hb_suppressed", busy_o, 0);
    end
    exp_q.push_back(3'b011);
    pulse_tick();
    wait_create(1);
    complete(2, 3'b011, 1'b0);
    heartBeatInt_i = 8'd0;

    // Timeout: four WAIT_DONE cycles, then pulse and regrant.
    exp_q.push_back(3'b100);
    seqreq_req_i = 1'b1;
    step();
    wait_create(1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_wait_busy", busy_o, 1);
      check("to_wait_no_pulse", timeout_o, 0);
    end
    step();
    check("timeout_pulse", timeout_o, 1);
    check("timeout_busy", busy_o, 0);
    check("timeout_seq", msgSeqNum_o, exp_seq);
    check("timeout_no_ack", seqreq_ack_o, 0);
    check("timeout_active", session_active_o, 1);
    exp_q.push_back(3'b100);
    step();
    check("timeout_pulse_end", timeout_o, 0);
    wait_create(0);
    complete(3, 3'b100, 1'b0);

    // Reset mid-message.
    exp_q.push_back(3'b100);
    seqreq_req_i = 1'b1;
    step();
    wait_create(1);
    step();
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    seqreq_req_i = 1'b0;
    exp_seq = 2'd1;
    exp_active = 1'b0;
    step();

    // Priority: logout beats seqreq; seqreq then ineligible.
    exp_q.push_back(3'b001);
    logon_req_i = 1'b1;
    step();
    wait_create(1);
    complete(1, 3'b001, 1'b0);
    exp_q.push_back(3'b010);
    logout_req_i = 1'b1;
    seqreq_req_i = 1'b1;
    step();
    wait_create(1);
    complete(2, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("seqreq_never_granted", {busy_o, seqreq_ack_o}, 0);
    end
    seqreq_req_i = 1'b0;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fix_session_scheduler.md
FIX_SESSION_SCHEDULER -- requirements
Module: fix_session_scheduler

Interface
REQ-001 Parameter SEQMEM_DEPTH, default 10, width of message sequence number.
REQ-002 Parameter DONE_TIMEOUT, default 255, max cycles waited for message completion.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 logon_req_i  input  1  level request for Logon; held until logon_ack_o.
REQ-006 logout_req_i  input  1  level request for Logout; held until logout_ack_o.
REQ-007 seqreq_req_i  input  1  level request for Sequence Request; held until seqreq_ack_o.
REQ-008 tick_i  input  1  one-cycle strobe, one per second.
REQ-009 heartBeatInt_i  input  8  heartbeat interval in seconds; 0 disables heartbeats.
REQ-010 msg_done_i  input  1  one-cycle strobe from message builder end-of-checksum.
REQ-011 create_message_o  output  1  one-cycle start strobe to message builder.
REQ-012 message_type_o  output  3  001 logon, 010 logout, 011 heartbeat, 100 seqReq.
REQ-013 msgSeqNum_o  output  SEQMEM_DEPTH  sequence number of current/next message.
REQ-014 logon_ack_o / logout_ack_o / seqreq_ack_o  output  1 each  one-cycle completion pulses.
REQ-015 session_active_o  output  1  high between completed Logon and completed Logout.
REQ-016 busy_o  output  1  high in ISSUE and WAIT_DONE.
REQ-017 timeout_o  output  1  one-cycle pulse when DONE_TIMEOUT expires.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT_DONE; IDLE -> ISSUE when any eligible request present; ISSUE -> WAIT_DONE unconditionally; WAIT_DONE -> IDLE on msg_done_i or timeout.
REQ-019 Eligibility: logon only when session inactive; logout, seqreq, heartbeat only when session active; ineligible requests ignored, held, never acked.
REQ-020 Fixed priority among eligible: logout > logon > seqreq > heartbeat.
REQ-021 Selection latched on IDLE->ISSUE edge; create_message_o high exactly during the ISSUE cycle (one cycle after request sampled in IDLE).
REQ-022 message_type_o valid from ISSUE through WAIT_DONE, stable; 000 in IDLE.
REQ-023 msg_done_i ignored in IDLE and ISSUE.
REQ-024 On msg_done_i in WAIT_DONE: pulse ack of granted type next cycle (none for heartbeat), increment msgSeqNum_o by 1.
REQ-025 Sequence wrap: all-ones increments to 1, never 0.
REQ-026 Logon completion sets session_active_o; logout completion clears it and reloads msgSeqNum_o to 1 (overrides increment).
REQ-027 Heartbeat counter (8 bit): counts tick_i only while session active and heartBeatInt_i != 0; on reaching heartBeatInt_i sets hb_pending and clears to 0.
REQ-028 Counter clears on every msg_done_i; if tick_i coincides with msg_done_i, clear wins.
REQ-029 hb_pending cleared when any message is granted (ISSUE entry) and when session inactive.
REQ-030 Timeout counter counts WAIT_DONE cycles; at DONE_TIMEOUT without msg_done_i: timeout_o pulse, return IDLE, no ack, no sequence increment, no session change.
REQ-031 heartBeatInt_i changes take effect immediately on next compare; counter value >= new interval triggers hb_pending on next tick.

Reset
REQ-032 rst sampled on clk edge, dominates all inputs, valid in any state including mid-message.
REQ-033 Reset values: FSM IDLE, create_message_o 0, message_type_o 000, msgSeqNum_o 1, all acks 0, session_active_o 0, busy_o 0, timeout_o 0, hb counter 0, hb_pending 0, timeout counter 0.
REQ-034 msg_done_i arriving the cycle after reset deasserts produces no ack.

Verification
REQ-035 Logon: rst released, logon_req_i=1 at cycle 0 -> create_message_o at cycle 1, type 001, seq 1; msg_done_i at cycle 5 -> logon_ack_o cycle 6, session_active_o=1, seq 2.
REQ-036 Priority: session active, logout_req_i and seqreq_req_i raised same cycle -> type 010 issued first; on completion seq reloads to 1, session inactive, seqreq never granted.
REQ-037 Heartbeat: active, heartBeatInt_i=3, no traffic, 3 tick_i -> create_message_o with type 011 within 2 cycles; no ack pulses; seq increments on done.
REQ-038 Heartbeat suppression: heartBeatInt_i=3, seqreq completes between 2nd and 3rd tick -> no heartbeat until 3 further ticks; tick coincident with msg_done_i does not count.
REQ-039 Timeout: DONE_TIMEOUT=4, grant seqreq, withhold msg_done_i -> timeout_o pulse after 4 WAIT_DONE cycles, back to IDLE, seq unchanged, seqreq regranted.
REQ-040 Wrap/reset: SEQMEM_DEPTH=2, seq 3 completes -> seq 1; rst asserted in WAIT_DONE -> all outputs at reset values next cycle.
